// File: rtl/matrix_pkg.sv
// Shared types and constants for the LED matrix frame streaming path.
package matrix_pkg;

  localparam int unsigned MATRIX_ROWS = 8;
  localparam int unsigned MATRIX_COLS = 8;

  typedef logic [MATRIX_COLS-1:0] row_t;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StSwap
  } stream_state_e;

  // Row index width; kept at least 1 bit so a single-row matrix still has a port.
  function automatic int unsigned row_idx_w(input int unsigned rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

endpackage

// File: rtl/matrix_frame_streamer_if.sv
// Game-side write port plus the row stream towards the matrix controller.
interface matrix_frame_streamer_if
  import matrix_pkg::*;
#(
  parameter int unsigned ROWS = MATRIX_ROWS,
  parameter int unsigned COLS = MATRIX_COLS
) ();

  localparam int unsigned ROW_W = row_idx_w(ROWS);

  logic             wr_en;
  logic [ROW_W-1:0] wr_row;
  logic [COLS-1:0]  wr_data;
  logic             wr_busy;
  logic             swap_req;
  logic             swap_ack;
  logic             out_valid;
  logic             out_ready;
  logic [ROW_W-1:0] out_row;
  logic [COLS-1:0]  out_data;
  logic             out_last;
  logic [7:0]       frame_cnt;

  modport master (
    input  wr_en, wr_row, wr_data, swap_req, out_ready,
    output wr_busy, swap_ack, out_valid, out_row, out_data, out_last, frame_cnt
  );

  modport slave (
    output wr_en, wr_row, wr_data, swap_req, out_ready,
    input  wr_busy, swap_ack, out_valid, out_row, out_data, out_last, frame_cnt
  );

endinterface

// File: rtl/frame_bank_pair.sv
// Double-buffered frame store: writes go to the back bank, reads come from the front bank.
module frame_bank_pair
  import matrix_pkg::*;
#(
  parameter int unsigned ROWS  = MATRIX_ROWS,
  parameter int unsigned COLS  = MATRIX_COLS,
  parameter int unsigned ROW_W = row_idx_w(ROWS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [ROW_W-1:0] wr_row,
  input  logic [COLS-1:0]  wr_data,
  input  logic             flip,
  input  logic             clear,
  input  logic [ROW_W-1:0] rd_row,
  output logic [COLS-1:0]  rd_data
);

  logic [COLS-1:0] bank_q [2][ROWS];
  logic [COLS-1:0] bank_d [2][ROWS];
  logic            front_q;

  // Clear hits the current front, which becomes the back bank after the flip.
  always_comb begin
    bank_d = bank_q;
    if (clear) begin
      for (int r = 0; r < int'(ROWS); r++) begin
        bank_d[front_q][r] = '0;
      end
    end
    if (wr_en && (32'(wr_row) < ROWS)) begin
      bank_d[~front_q][wr_row] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < int'(ROWS); r++) begin
          bank_q[b][r] <= '0;
        end
      end
      front_q <= 1'b0;
    end else begin
      bank_q <= bank_d;
      if (flip) begin
        front_q <= ~front_q;
      end
    end
  end

  assign rd_data = bank_q[front_q][rd_row];

endmodule

// File: rtl/matrix_frame_streamer.sv
// Streams the committed front frame row by row; swaps banks only between frames.
module matrix_frame_streamer
  import matrix_pkg::*;
#(
  parameter int unsigned ROWS          = MATRIX_ROWS,
  parameter int unsigned COLS          = MATRIX_COLS,
  parameter bit          CLEAR_ON_SWAP = 1'b1
) (
  input logic                    clk,
  input logic                    rst,
  matrix_frame_streamer_if.master bus
);

  localparam int unsigned ROW_W = row_idx_w(ROWS);

  stream_state_e    state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             last_q, last_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ack_q, ack_d;
  logic             pending_q, pending_d;
  logic             wr_busy_q;
  logic             flip;
  logic             clear;
  logic             wr_ok;
  logic [COLS-1:0]  rd_data;

  assign wr_ok = bus.wr_en && !wr_busy_q;

  frame_bank_pair #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .ROW_W (ROW_W)
  ) u_banks (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_ok),
    .wr_row  (bus.wr_row),
    .wr_data (bus.wr_data),
    .flip    (flip),
    .clear   (clear),
    .rd_row  (row_q),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    ack_d     = 1'b0;
    pending_d = pending_q | bus.swap_req;
    flip      = 1'b0;
    clear     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pending_q || bus.swap_req) begin
          state_d = StSwap;
        end
      end
      StSend: begin
        if (bus.out_ready) begin
          if (last_q) begin
            cnt_d  = cnt_q + 8'd1;
            row_d  = '0;
            last_d = (ROWS == 32'd1);
            if (pending_q || bus.swap_req) begin
              state_d = StSwap;
            end
          end else begin
            row_d  = row_q + ROW_W'(1);
            last_d = (row_q == ROW_W'(ROWS - 2));
          end
        end
      end
      StSwap: begin
        flip      = 1'b1;
        clear     = CLEAR_ON_SWAP;
        pending_d = 1'b0;
        ack_d     = 1'b1;
        row_d     = '0;
        last_d    = (ROWS == 32'd1);
        state_d   = StSend;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      row_q     <= '0;
      last_q    <= 1'b0;
      cnt_q     <= '0;
      ack_q     <= 1'b0;
      pending_q <= 1'b0;
      wr_busy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      pending_q <= pending_d;
      wr_busy_q <= pending_q;
    end
  end

  // The front bank never changes while streaming, so the registered row index
  // selects stable data for the whole time a row is presented.
  assign bus.out_valid = (state_q == StSend);
  assign bus.out_row   = row_q;
  assign bus.out_data  = rd_data;
  assign bus.out_last  = last_q;
  assign bus.swap_ack  = ack_q;
  assign bus.wr_busy   = wr_busy_q;
  assign bus.frame_cnt = cnt_q;

endmodule

// File: doc/matrix_frame_streamer.md
Name: matrix_frame_streamer

Overview:
- Game-side transmitter for the 8x8 LED matrix path: it produces the row stream that the matrix controller consumes on its matrixIn input.
- Holds two 8x8 frame banks (double buffer). The game writes rows into the back bank, then commits it with a swap request.
- The committed front bank is streamed continuously, row 0..7, over a valid/ready handshake.
- Swaps happen only at frame boundaries, so the matrix never shows a torn frame.

Parameters:
- ROWS, 8, number of matrix rows per frame
- COLS, 8, bits per row (one bit per column, 1 = LED on)
- ROW_W, $clog2(ROWS), row index width (derived, not overridden)
- CLEAR_ON_SWAP, 1, when 1 the new back bank is zeroed in the SWAP cycle

Ports:
- clk  in  1  system clock, single clock domain
- rst  in  1  synchronous, active-low reset (sampled on rising clk; rst==0 resets)
- wr_en  in  1  write strobe for the back bank
- wr_row  in  ROW_W  row index for the write
- wr_data  in  COLS  row pixel data
- wr_busy  out  1  high while a swap is pending; writes are dropped while high
- swap_req  in  1  commit back bank (pulse or level; edge not required)
- swap_ack  out  1  one-cycle pulse in the cycle after the bank flip
- out_valid  out  1  stream data valid
- out_ready  in  1  downstream accepts the row
- out_row  out  ROW_W  index of the row presented
- out_data  out  COLS  pixel data of the row presented
- out_last  out  1  high with row ROWS-1
- frame_cnt  out  8  number of completed frames, wraps 255->0

Behaviour:
- Reset (rst==0 at a clock edge):
  - state=IDLE; front=bank0; both banks all zero.
  - out_valid=0, out_row=0, out_data=0, out_last=0.
  - swap_ack=0, wr_busy=0, swap_pending=0, frame_cnt=0.
  - Reset mid-frame or mid-swap abandons everything; no ack is issued.
- Writes:
  - wr_en && !wr_busy writes wr_data into back[wr_row] at the clock edge.
  - Writes are legal in every state except while wr_busy is high; during wr_busy they are dropped silently.
  - wr_row >= ROWS is ignored. This only matters when ROWS is not a power of two.
- swap_pending:
  - Set by swap_req. wr_busy is a registered copy of swap_pending.
  - A swap_req while already pending has no extra effect; only one swap is taken.
- States:
  - IDLE: out_valid=0. swap_req (or pending) -> SWAP next cycle. Nothing is streamed until the first commit.
  - SEND: out_valid=1. out_row, out_data=front[out_row] and out_last are registered.
    - A transfer occurs when out_valid && out_ready.
    - All outputs are held stable while out_valid && !out_ready.
    - On a transfer of a row < ROWS-1, the next cycle presents row+1 (zero-bubble back-to-back).
    - On a transfer with out_last: frame_cnt increments.
    - If swap_pending or swap_req is high in that same cycle, go to SWAP. Otherwise present row 0 of the same front next cycle.
  - SWAP: exactly one cycle, out_valid=0. front flips at the end of the cycle.
    - If CLEAR_ON_SWAP, the bank that becomes back is zeroed.
    - swap_pending clears; next state is SEND with row 0 of the new front.
    - swap_ack pulses in the first SEND cycle.
- Latency:
  - Swap request mid-frame: the swap waits for the remaining rows, then adds 1 bubble cycle.
  - From IDLE: swap_req at cycle N gives SWAP at N+1, then out_valid=1 with row 0 and swap_ack=1 at N+2.
- Simultaneous events:
  - swap_req together with wr_en (while wr_busy=0) in the same cycle: the write lands and is part of the committed frame.
  - out_ready low for any length, including across a pending swap: no rows are skipped and no swap is taken early.

Decomposition:
- Shared package matrix_pkg holds:
  - constants MATRIX_ROWS=8 and MATRIX_COLS=8;
  - typedef row_t (logic [MATRIX_COLS-1:0]);
  - an enum for the streamer states IDLE/SEND/SWAP.
- One sub-module is natural: frame_bank_pair. It holds two row_t arrays and provides:
  - a write port to the back bank;
  - an asynchronous read of the front bank;
  - a flip input and a clear input.
- The FSM, handshake and counters stay in the top of the block.

Test Plan:
- Reset and idle:
  - Stimulus: hold rst=0 for 3 cycles, release, run 20 cycles with no swap_req.
  - Required: out_valid=0 throughout, frame_cnt=0, swap_ack never high.
- First commit and streaming:
  - Stimulus: write rows r -> 8'h01<<r, pulse swap_req, hold out_ready=1.
  - Required: swap_ack appears 2 cycles after swap_req.
  - Required: then 8 consecutive transfers with out_data 01,02,...,80 and out_last on row 7.
  - Required: the frame repeats and frame_cnt increments once every 8 cycles.
- Backpressure:
  - Stimulus: toggle out_ready with pattern 1,0,0,1.
  - Required: out_row and out_data are unchanged during the low cycles; row order is still 0..7 with no skips or duplicates.
- Mid-frame swap:
  - Stimulus: while row 3 is presented, write back rows = 8'hAA and pulse swap_req.
  - Required: rows 3..7 of the old frame still go out, then one bubble cycle, then rows of AA.
  - Required: writes issued while wr_busy=1 are absent from the new frame; with CLEAR_ON_SWAP=1 the back bank reads 00 after the swap.
- Boundary swap:
  - Stimulus: swap_req in the same cycle as the row 7 transfer.
  - Required: SWAP happens the next cycle with no extra frame; row 0 of the new frame follows the 1 bubble cycle.
- Counter wrap and reset mid-operation:
  - Stimulus: run 256 frames, then assert rst=0 during row 4.
  - Required: frame_cnt wraps 255->0; after reset, outputs, banks and frame_cnt are all back at their reset values.
